// File: rtl/uart_rx_buf.sv
// UART receiver with a single-entry holding register and valid/ready hand-off.
// Optional parity; frames completing while the holding register is full are dropped.
module uart_rx_buf #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxout,
    output logic       rxvalid,
    input  logic       rxready,
    output logic       rxdone,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [7:0]    rxout_q, rxout_d;
    logic          rxvalid_q, rxvalid_d;
    logic          ferr_q, ferr_d;
    logic          perr_q, perr_d;
    logic          done_c, ovr_c, free;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        rxout_d   = rxout_q;
        rxvalid_d = rxvalid_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        done_c    = 1'b0;
        ovr_c     = 1'b0;
        free      = !rxvalid_q || rxready;

        if (rxvalid_q && rxready) begin
            rxvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Edge-triggered start so a held-low line cannot re-arm
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s_q, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_c  = 1'b1;
                    if (free) begin
                        rxout_d   = shreg_q;
                        rxvalid_d = 1'b1;
                        ferr_d    = !rx_s_q;
                        perr_d    = PAR_EN && ((^shreg_q) ^ par_q ^ PAR_ODD);
                    end else begin
                        ovr_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            rxout_q   <= '0;
            rxvalid_q <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            rxout_q   <= rxout_d;
            rxvalid_q <= rxvalid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    assign rxout      = rxout_q;
    assign rxvalid    = rxvalid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign rxdone     = done_c && !rst;
    assign overrun    = ovr_c && !rst;

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clocks per serial bit; legal values >= 4.
REQ-002 SHALL have parameter PARITY_EN, default 0, where 1 expects one parity bit between D7 and stop.
REQ-003 SHALL have parameter PARITY_ODD, default 0, where 0 means even parity and 1 means odd; ignored when PARITY_EN=0.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rxout  output  8  received byte, LSB first on the line.
REQ-008 SHALL have port rxvalid  output  1  rxout holds an unconsumed byte.
REQ-009 SHALL have port rxready  input  1  consumer accepts rxout when rxvalid=1.
REQ-010 SHALL have port rxdone  output  1  one-cycle pulse at each completed frame.
REQ-011 SHALL have port frame_err  output  1  stop bit of the byte in rxout sampled 0.
REQ-012 SHALL have port parity_err  output  1  parity of the byte in rxout mismatched.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; all decisions use the synced value (rx_s).
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-016 SHALL leave IDLE only on a 1->0 transition of rx_s, so a line held low (break) never re-arms; call the first rx_s=0 cycle T.
REQ-017 SHALL, in START, sample rx_s at T+CLKS_PER_BIT/2 (integer division); sample 1 -> false start, return to IDLE with no output change.
REQ-018 SHALL sample data bit i (i=0..7) at T+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT and shift LSB first.
REQ-019 SHALL sample the parity bit, when enabled, at T+CLKS_PER_BIT/2+9*CLKS_PER_BIT; the stop bit one CLKS_PER_BIT after the last data/parity sample.
REQ-020 SHALL pulse rxdone in the stop-sample cycle, then enter IDLE the next cycle (half-bit early, for resync).
REQ-021 SHALL, at the stop sample, when the holding register is free, load rxout, frame_err and parity_err and set rxvalid the next cycle; free means rxvalid=0, or rxvalid=1 with rxready=1 in the same cycle.
REQ-022 SHALL, when the holding register is not free at the stop sample, pulse overrun, drop the new byte, and leave rxout, rxvalid and error flags unchanged.
REQ-023 SHALL clear rxvalid on rxvalid&&rxready unless a new byte loads in the same cycle, in which case rxvalid stays 1.
REQ-024 SHALL keep rxout, frame_err and parity_err stable while rxvalid=1.
REQ-025 SHALL load a frame with a stop-bit error normally (byte plus frame_err=1); rxdone still pulses.
REQ-026 SHALL use a bit-timer counter of width clog2(CLKS_PER_BIT) that wraps to 0 at each sample point, and a 3-bit bit index; no other arithmetic.

Reset
REQ-027 SHALL set, on rst=1 at a clock edge: state IDLE, rxout=0x00, rxvalid=0, rxdone=0, frame_err=0, parity_err=0, overrun=0, counters 0.
REQ-028 SHALL reset the synchronizer flops to 1 so that releasing reset causes no false start.
REQ-029 SHALL, on rst mid-frame, abort the frame with no rxdone; the next clean frame after release is received correctly.
REQ-030 SHALL give rst priority over every other event in the same cycle.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-031 SHALL cover: 8N1 frame 0xA5, rxready=1 -> one rxdone pulse, rxout=0xA5, rxvalid high 1 cycle, frame_err=0, parity_err=0.
REQ-032 SHALL cover: rx low for 4 clocks then high -> no rxdone, state back to IDLE, outputs unchanged.
REQ-033 SHALL cover: frame 0x3C with stop bit 0 -> rxout=0x3C, frame_err=1, rxdone pulses; line then held low 40 bit times -> no further rxdone.
REQ-034 SHALL cover: frames 0x11 then 0x22, rxready=0 -> rxout stays 0x11, overrun pulses once at the second stop sample; repeat with rxready=1 exactly at that cycle -> rxout=0x22, no overrun.
REQ-035 SHALL cover: PARITY_EN=1, PARITY_ODD=0, byte 0x07 with parity bit 0 -> rxout=0x07, parity_err=1; same byte with parity bit 1 -> parity_err=0.
REQ-036 SHALL cover: rst pulsed during data bit 3 -> no rxdone, rxvalid=0; next frame 0x5A -> rxout=0x5A.
